mem_wb_stage: RTL
=================

// Module: mem_wb_stage
// PURPOSE
//  Consumer side of the ID/EX control/data bundle (wE_BR, SEL_dmx, W_ram, R_ram, wa_BR).
//  Takes the bundle plus the ALU result, runs the data-RAM access over a req/ack handshake,
//  and drives the register-bank write-back port.
//  Back-pressures the upstream stage while a RAM access is outstanding.
//  Sits between the ALU output and the register bank's write port.
// PARAMETERS
//  DATA_W  32  datapath width (ALU result, store data, RAM data, write-back data)
//  ADDR_W  8   RAM word-address width; address = in_alu_res[ADDR_W-1:0]
//  REG_AW  5   register-bank address width
// PORTS
//  clk            in   1       clock, all state on rising edge
//  rst_n          in   1       asynchronous active-low reset
//  in_valid       in   1       upstream bundle valid this cycle
//  in_ready       out  1       stage can accept; transfer = in_valid & in_ready
//  flush          in   1       discard accepted op not yet written back
//  in_wE_BR       in   1       op writes the register bank
//  in_SEL_dmx     in   1       write-back source: 1 = RAM read data, 0 = ALU result
//  in_W_ram       in   1       store
//  in_R_ram       in   1       load
//  in_alu_res     in   DATA_W  ALU result / RAM address
//  in_store_data  in   DATA_W  store data (DR2 path)
//  in_wa          in   REG_AW  destination register
//  ram_req        out  1       RAM request, held until ram_ack
//  ram_we         out  1       1 = write, 0 = read; stable while ram_req
//  ram_addr       out  ADDR_W  RAM address; stable while ram_req
//  ram_wdata      out  DATA_W  RAM write data; stable while ram_req
//  ram_rdata      in   DATA_W  RAM read data, valid in the ram_ack cycle
//  ram_ack        in   1       RAM completion strobe (1 cycle)
//  wb_we          out  1       register-bank write enable (1-cycle pulse)
//  wb_wa          out  REG_AW  write-back register address
//  wb_data        out  DATA_W  write-back data
// BEHAVIOUR
//  Reset: FSM = IDLE; ram_req, ram_we, wb_we = 0.
//    ram_addr, ram_wdata, wb_wa, wb_data = 0; captured bundle cleared.
//  FSM states: IDLE, ACCESS, WB.
//  IDLE: in_ready = 1.
//    On transfer, capture the whole bundle.
//    W_ram | R_ram -> ACCESS; ram_req = 1 from the next cycle.
//    Otherwise -> WB.
//  ACCESS: in_ready = 0; ram_req held with stable ram_we/addr/wdata.
//    On ram_ack: ram_req drops the following cycle.
//    Load: capture ram_rdata.
//    Next state -> WB; an ack with no pending access is ignored.
//  WB: one cycle. wb_we = wE_BR & (wa != 0); writes to register 0 are suppressed.
//    wb_data = SEL_dmx ? captured RAM data : alu_res.
//    Then -> IDLE. in_ready = 1 in WB, so back-to-back ops need no bubble.
//  Latency: ALU op accepted at edge N -> wb_we high during cycle N+1.
//    Load acked in cycle M -> wb_we high in cycle M+1.
//    Store: no write-back unless wE_BR is set; then the ALU result is written.
//  R_ram & W_ram both set: treated as a store; R_ram is ignored.
//  SEL_dmx = 1 without R_ram: wb_data = 0.
//  Flush:
//    In IDLE, the incoming op is dropped.
//    In ACCESS: ram_req stays high until ram_ack (no abandoned transactions).
//      Write-back is then suppressed and the FSM returns to IDLE.
//    In WB: wb_we forced to 0.
//  Reset mid-access: immediate return to IDLE; ram_req deasserts asynchronously.
// STRUCTURE
//  Shared package: FSM state encoding (IDLE/ACCESS/WB); default widths.
//    Also a packed bundle typedef {wE_BR, SEL_dmx, W_ram, R_ram, wa, alu_res, store_data}.
//  Sub-module mem_wb_ctrl: the FSM + handshake only.
//    Datapath capture registers and the write-back mux stay in the top.
// TESTING
//  1. ALU op: wE=1, SEL=0, alu_res=0x0000_00AA, wa=5.
//     -> next cycle wb_we=1, wb_wa=5, wb_data=0xAA; ram_req never rises.
//  2. Load: R_ram=1, SEL=1, wE=1, alu_res=0x10, wa=7.
//     ram_ack 3 cycles after ram_req with rdata=0xDEAD_BEEF.
//     -> ram_addr=0x10, ram_we=0, in_ready=0 throughout; then wb_we=1, wa=7, data=0xDEADBEEF.
//  3. Store: W_ram=1, wE=0, alu_res=0x20, store_data=0x1234.
//     -> ram_we=1, addr=0x20, wdata=0x1234 held until ack; no wb_we.
//  4. wE=1, wa=0, ALU op -> wb_we stays 0.
//  5. Flush during ACCESS of a load.
//     -> ram_req stays high until ram_ack, then no wb_we.
//     -> FSM back in IDLE with in_ready=1.
//  6. Back-to-back ALU ops every cycle -> wb_we high on consecutive cycles.
//     rst_n low mid-load -> ram_req=0 and wb_we=0 immediately.

Source files
------------

// File: rtl/mem_wb_pkg.sv
// -----------------------------------------------------------------------------
// mem_wb_pkg
//   Shared definitions for the MEM/WB stage:
//     - default datapath widths
//     - FSM state encoding (IDLE / ACCESS / WB)
//     - packed ID/EX control/data bundle captured by the stage
//     - small helpers that classify a captured bundle
// -----------------------------------------------------------------------------
package mem_wb_pkg;

  localparam int unsigned DATA_W_DEF = 32;
  localparam int unsigned ADDR_W_DEF = 8;
  localparam int unsigned REG_AW_DEF = 5;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ACCESS = 2'd1,
    ST_WB     = 2'd2
  } mem_wb_state_e;

  typedef struct packed {
    logic                  wE_BR;
    logic                  SEL_dmx;
    logic                  W_ram;
    logic                  R_ram;
    logic [REG_AW_DEF-1:0] wa;
    logic [DATA_W_DEF-1:0] alu_res;
    logic [DATA_W_DEF-1:0] store_data;
  } mem_wb_bundle_t;

  // Any op that touches the data RAM.
  function automatic logic is_mem_op(input mem_wb_bundle_t b);
    return b.W_ram | b.R_ram;
  endfunction

  // A store wins when both R_ram and W_ram are set, so only a pure read is a load.
  function automatic logic is_load(input mem_wb_bundle_t b);
    return b.R_ram & ~b.W_ram;
  endfunction

endpackage

// File: rtl/mem_wb_ctrl.sv
// -----------------------------------------------------------------------------
// mem_wb_ctrl
//   Control FSM and RAM req/ack handshake of the MEM/WB stage. No datapath.
//
//   state  | meaning
//   -------+----------------------------------------------------------------
//   IDLE   | no op in flight; ready for a new bundle
//   ACCESS | RAM request outstanding; upstream stalled until ram_ack
//   WB     | single write-back cycle; a new bundle may be accepted here
//
//   Ports
//     clk, rst_n    clock, async active-low reset
//     in_valid_i    upstream bundle valid
//     flush_i       discard the op in flight / the op offered this cycle
//     mem_op_i      offered bundle is a load or store
//     ram_ack_i     RAM completion strobe
//     in_ready_o    stage can accept a bundle
//     ram_req_o     RAM request, held until ram_ack_i
//     capture_o     load the offered bundle into the top's capture registers
//     rdata_en_o    ack of the outstanding access (RAM data valid)
//     wb_valid_o    write-back cycle that has not been flushed
// -----------------------------------------------------------------------------
module mem_wb_ctrl
  import mem_wb_pkg::*;
(
  input  logic clk,
  input  logic rst_n,
  input  logic in_valid_i,
  input  logic flush_i,
  input  logic mem_op_i,
  input  logic ram_ack_i,
  output logic in_ready_o,
  output logic ram_req_o,
  output logic capture_o,
  output logic rdata_en_o,
  output logic wb_valid_o
);

  mem_wb_state_e state_q;
  logic          in_ready_q;
  logic          ram_req_q;
  logic          wb_pend_q;
  logic          flush_seen_q;
  logic          transfer;

  // A flushed offer is dropped even though in_ready is high.
  assign transfer = in_valid_i & in_ready_q & ~flush_i;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= ST_IDLE;
      in_ready_q   <= 1'b1;
      ram_req_q    <= 1'b0;
      wb_pend_q    <= 1'b0;
      flush_seen_q <= 1'b0;
    end else begin
      case (state_q)
        ST_IDLE, ST_WB: begin
          flush_seen_q <= 1'b0;
          if (transfer && mem_op_i) begin
            state_q    <= ST_ACCESS;
            in_ready_q <= 1'b0;
            ram_req_q  <= 1'b1;
            wb_pend_q  <= 1'b0;
          end else if (transfer) begin
            state_q   <= ST_WB;
            wb_pend_q <= 1'b1;
          end else begin
            state_q   <= ST_IDLE;
            wb_pend_q <= 1'b0;
          end
        end
        ST_ACCESS: begin
          if (ram_ack_i) begin
            ram_req_q    <= 1'b0;
            in_ready_q   <= 1'b1;
            flush_seen_q <= 1'b0;
            // A flush seen at any point during the access cancels write-back,
            // but the RAM transaction itself is always completed.
            if (flush_seen_q || flush_i) begin
              state_q   <= ST_IDLE;
              wb_pend_q <= 1'b0;
            end else begin
              state_q   <= ST_WB;
              wb_pend_q <= 1'b1;
            end
          end else if (flush_i) begin
            flush_seen_q <= 1'b1;
          end
        end
        default: begin
          state_q      <= ST_IDLE;
          in_ready_q   <= 1'b1;
          ram_req_q    <= 1'b0;
          wb_pend_q    <= 1'b0;
          flush_seen_q <= 1'b0;
        end
      endcase
    end
  end

  assign in_ready_o = in_ready_q;
  assign ram_req_o  = ram_req_q;
  assign capture_o  = transfer;
  // Acks arriving with no request outstanding are ignored.
  assign rdata_en_o = ram_ack_i & ram_req_q;
  assign wb_valid_o = wb_pend_q & ~flush_i;

endmodule

// File: rtl/mem_wb_stage.sv
// -----------------------------------------------------------------------------
// mem_wb_stage
//   Consumer of the ID/EX control/data bundle. Performs the data-RAM access
//   over a req/ack handshake and drives the register-bank write port.
//   Upstream is stalled (in_ready low) while a RAM access is outstanding.
//
//   Ports
//     clk, rst_n                clock, async active-low reset
//     in_valid / in_ready       upstream handshake
//     flush                     discard op not yet written back
//     in_wE_BR .. in_wa         incoming bundle fields
//     ram_req/we/addr/wdata     RAM request side, stable while ram_req
//     ram_rdata / ram_ack       RAM response side
//     wb_we / wb_wa / wb_data   register-bank write port
//
//   The bundle typedef is sized by the package defaults; the width
//   parameters here must be kept equal to those defaults.
// -----------------------------------------------------------------------------
module mem_wb_stage
  import mem_wb_pkg::*;
#(
  parameter int unsigned DATA_W = DATA_W_DEF,
  parameter int unsigned ADDR_W = ADDR_W_DEF,
  parameter int unsigned REG_AW = REG_AW_DEF
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic              flush,
  input  logic              in_wE_BR,
  input  logic              in_SEL_dmx,
  input  logic              in_W_ram,
  input  logic              in_R_ram,
  input  logic [DATA_W-1:0] in_alu_res,
  input  logic [DATA_W-1:0] in_store_data,
  input  logic [REG_AW-1:0] in_wa,
  output logic              ram_req,
  output logic              ram_we,
  output logic [ADDR_W-1:0] ram_addr,
  output logic [DATA_W-1:0] ram_wdata,
  input  logic [DATA_W-1:0] ram_rdata,
  input  logic              ram_ack,
  output logic              wb_we,
  output logic [REG_AW-1:0] wb_wa,
  output logic [DATA_W-1:0] wb_data
);

  mem_wb_bundle_t    bundle_d;
  mem_wb_bundle_t    bundle_q;
  logic [DATA_W-1:0] rdata_q;
  logic              capture;
  logic              rdata_en;
  logic              wb_valid;
  logic              ram_req_int;

  always_comb begin
    bundle_d            = '0;
    bundle_d.wE_BR      = in_wE_BR;
    bundle_d.SEL_dmx    = in_SEL_dmx;
    bundle_d.W_ram      = in_W_ram;
    bundle_d.R_ram      = in_R_ram;
    bundle_d.wa         = in_wa;
    bundle_d.alu_res    = in_alu_res;
    bundle_d.store_data = in_store_data;
  end

  mem_wb_ctrl u_ctrl (
    .clk        (clk),
    .rst_n      (rst_n),
    .in_valid_i (in_valid),
    .flush_i    (flush),
    .mem_op_i   (is_mem_op(bundle_d)),
    .ram_ack_i  (ram_ack),
    .in_ready_o (in_ready),
    .ram_req_o  (ram_req_int),
    .capture_o  (capture),
    .rdata_en_o (rdata_en),
    .wb_valid_o (wb_valid)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bundle_q <= '0;
      rdata_q  <= '0;
    end else begin
      if (capture) begin
        bundle_q <= bundle_d;
      end
      if (rdata_en && is_load(bundle_q)) begin
        rdata_q <= ram_rdata;
      end
    end
  end

  // The bundle cannot change during ACCESS (in_ready is low), so the request
  // fields are naturally stable for the whole transaction.
  assign ram_req   = ram_req_int;
  assign ram_we    = ram_req_int & bundle_q.W_ram;
  assign ram_addr  = bundle_q.alu_res[ADDR_W-1:0];
  assign ram_wdata = bundle_q.store_data;

  // Register 0 is hard-wired; writes to it are dropped.
  assign wb_we = wb_valid & bundle_q.wE_BR & (bundle_q.wa != '0);
  assign wb_wa = bundle_q.wa;

  // RAM data only exists for a true load; any other SEL_dmx=1 op writes zero.
  always_comb begin
    wb_data = bundle_q.alu_res;
    if (bundle_q.SEL_dmx) begin
      wb_data = is_load(bundle_q) ? rdata_q : '0;
    end
  end

endmodule
